spi_ram: RTL and testbench
==========================

# spi_ram

Single-port synchronous RAM that sits directly downstream of the SPI slave. It decodes each 10-bit word the slave delivers on `rx_data`/`rx_valid` as a 2-bit command plus an 8-bit payload. It latches write and read addresses, performs writes, and returns read data on `tx_data`/`tx_valid` for the slave to shift out on MISO. Memory contents are not reset; all control state is.

## Interface
Parameters:
- `MEM_DEPTH`, 256, number of 8-bit words; legal range 2..256.
- `ADDR_SIZE`, 8, address register width; must satisfy 2^ADDR_SIZE >= MEM_DEPTH.
- `AUTO_INC`, 1, when 1 the write/read address post-increments after each data access.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `rx_data`  in  10  command word: [9:8] = cmd, [7:0] = payload.
- `rx_valid`  in  1  level from the slave; held high while a word is presented.
- `tx_data`  out  8  read data for the slave.
- `tx_valid`  out  1  `tx_data` is valid; held until cleared (see Operation).
- `addr_err`  out  1  one-cycle pulse when an address command is rejected.

## Operation
- **Edge detect.** Register `rx_valid_d` samples `rx_valid` every cycle. A command is accepted only in a cycle where `rx_valid=1 && rx_valid_d=0`. Holding `rx_valid` high never re-executes a command.
- **Commands** (on an accepted edge; `p` = `rx_data[7:0]`):
  - `00` (write address): if `p < MEM_DEPTH`, `wr_addr <= p[ADDR_SIZE-1:0]`. Otherwise `wr_addr` is unchanged and `addr_err` pulses.
  - `01` (write data): `mem[wr_addr] <= p`. If `AUTO_INC`, `wr_addr <= (wr_addr == MEM_DEPTH-1) ? 0 : wr_addr+1`.
  - `10` (read address): if `p < MEM_DEPTH`, `rd_addr <= p`. Otherwise `rd_addr` is unchanged and `addr_err` pulses.
  - `11` (read data): `tx_data <= mem[rd_addr]` and `tx_valid <= 1`. If `AUTO_INC`, `rd_addr` increments with the same wrap rule as `wr_addr`. Payload is ignored.
- **`tx_valid` clear.** `tx_valid` stays high until the next accepted command whose cmd is not `11`; it then clears on that edge. A new `11` reloads `tx_data` and keeps `tx_valid=1`.
- **`tx_data` hold.** `tx_data` holds its last value whenever `tx_valid=0`.
- **Port arbitration.** Single port: at most one memory access per cycle, guaranteed by edge-only acceptance.
- **Reset values** (immediate on `rst` assertion, independent of `clk`):
  - `tx_data=0`, `tx_valid=0`, `addr_err=0`
  - `wr_addr=0`, `rd_addr=0`, `rx_valid_d=0`
  - Memory contents are untouched.
- **Reset mid-operation.** An accepted command whose edge coincides with `rst` high is discarded. After `rst` deasserts, a `rx_valid` that is already high counts as a new edge (since `rx_valid_d=0`) and executes once.
- **Unwritten locations** read X in simulation. Benches must initialise before reading.

## Timing
- **Latency.** Command accepted at edge N. Its effects (address register, memory write, `tx_data`/`tx_valid`, `addr_err`) are visible after edge N, i.e. in cycle N+1.
- **Write-then-read.** A write to address A followed by a read of A on the next accepted edge returns the new data; memory is written before the read edge samples it.
- **Edge spacing.** Minimum spacing between accepted commands is 2 cycles, because `rx_valid` must drop for at least one cycle. Upstream actually spaces commands by 12 or more cycles.
- **`addr_err`** is high for exactly one cycle per rejected command.
- **Slave handshake.** `tx_valid` is stable for the whole time the slave shifts the 8 bits out, since it is held until the next accepted non-read command.

## Test plan
- **Reset.** Drive `rst=1` mid-cycle with `clk` stopped → `tx_valid`, `tx_data`, `addr_err` all 0 immediately.
- **Basic write/read.** Send `0x000|0x12`, `0x100|0xA5`, `0x200|0x12`, `0x300` → `tx_data=0xA5`, `tx_valid=1` one cycle after the fourth edge.
- **Auto-increment and wrap.** With `MEM_DEPTH=256`, write address `0xFF`, then data `0x11`, then data `0x22` → `mem[0xFF]=0x11`, `mem[0x00]=0x22`. Read address `0xFF` followed by two `11` commands → `tx_data` is `0x11` then `0x22`.
- **Level hold.** Hold `rx_valid` high for 20 cycles with cmd `01` → exactly one write; `wr_addr` advances by 1 only.
- **Out-of-range address.** With `MEM_DEPTH=128`, send `0x000|0x80` → `addr_err` is a single 1-cycle pulse and `wr_addr` is unchanged.
- **`tx_valid` clear and reset mid-command.** A `00` command after a read clears `tx_valid` on its edge. Asserting `rst` on the edge of a `01` command → memory is unmodified; after `rst` deasserts with `rx_valid` still high, the write executes once.

Source files
------------

// File: rtl/spi_ram.sv
// spi_ram: command-decoded single-port RAM sitting behind an SPI slave.
// Each rising edge of rx_valid delivers one {cmd, payload} word; reads return on tx_data/tx_valid.
module spi_ram #(
  parameter int unsigned MEM_DEPTH = 256,
  parameter int unsigned ADDR_SIZE = 8,
  parameter bit          AUTO_INC  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  output logic       addr_err
);

  localparam int unsigned DATA_W = 8;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(MEM_DEPTH - 1);

  logic [DATA_W-1:0]    mem [MEM_DEPTH];

  logic                 rx_valid_d_q;
  logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_SIZE-1:0] rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0]    tx_data_q, tx_data_d;
  logic                 tx_valid_q, tx_valid_d;
  logic                 addr_err_q, addr_err_d;
  logic                 mem_we;

  logic                 accept;
  logic [1:0]           cmd;
  logic [DATA_W-1:0]    payload;
  logic                 in_range;

  assign cmd      = rx_data[9:8];
  assign payload  = rx_data[7:0];
  assign accept   = rx_valid && !rx_valid_d_q;
  assign in_range = 32'(payload) < MEM_DEPTH;

  // Command decode: next address, read data, status and write enable
  always_comb begin
    wr_addr_d  = wr_addr_q;
    rd_addr_d  = rd_addr_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    addr_err_d = 1'b0;
    mem_we     = 1'b0;
    if (accept) begin
      if (cmd != CMD_RD_DATA) tx_valid_d = 1'b0;
      case (cmd)
        CMD_WR_ADDR: begin
          if (in_range) wr_addr_d = ADDR_SIZE'(payload);
          else          addr_err_d = 1'b1;
        end
        CMD_WR_DATA: begin
          mem_we = 1'b1;
          if (AUTO_INC)
            wr_addr_d = (wr_addr_q == LAST_ADDR) ? '0 : wr_addr_q + ADDR_SIZE'(1);
        end
        CMD_RD_ADDR: begin
          if (in_range) rd_addr_d = ADDR_SIZE'(payload);
          else          addr_err_d = 1'b1;
        end
        default: begin
          tx_data_d  = mem[rd_addr_q];
          tx_valid_d = 1'b1;
          if (AUTO_INC)
            rd_addr_d = (rd_addr_q == LAST_ADDR) ? '0 : rd_addr_q + ADDR_SIZE'(1);
        end
      endcase
    end
  end

  // Control state; a command coinciding with reset is dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_valid_d_q <= 1'b0;
      wr_addr_q    <= '0;
      rd_addr_q    <= '0;
      tx_data_q    <= '0;
      tx_valid_q   <= 1'b0;
      addr_err_q   <= 1'b0;
    end else begin
      rx_valid_d_q <= rx_valid;
      wr_addr_q    <= wr_addr_d;
      rd_addr_q    <= rd_addr_d;
      tx_data_q    <= tx_data_d;
      tx_valid_q   <= tx_valid_d;
      addr_err_q   <= addr_err_d;
    end
  end

  // Storage array: not reset, write suppressed while rst is high
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem[wr_addr_q] <= payload;
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign addr_err = addr_err_q;

endmodule

// File: tb/tb_spi_ram.sv
// tb_spi_ram: directed bench for spi_ram, full-depth and 128-deep instances.
module tb_spi_ram;

  logic       clk = 1'b0;
  logic       clk_en = 1'b0;
  logic       rst = 1'b0;

  logic [9:0] rx_data_a = '0, rx_data_b = '0;
  logic       rx_valid_a = 1'b0, rx_valid_b = 1'b0;
  logic [7:0] tx_data_a, tx_data_b;
  logic       tx_valid_a, tx_valid_b;
  logic       addr_err_a, addr_err_b;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q [$];

  spi_ram #(.MEM_DEPTH(256), .ADDR_SIZE(8), .AUTO_INC(1'b1)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data_a), .rx_valid(rx_valid_a),
    .tx_data(tx_data_a), .tx_valid(tx_valid_a), .addr_err(addr_err_a)
  );

  spi_ram #(.MEM_DEPTH(128), .ADDR_SIZE(8), .AUTO_INC(1'b1)) dut128 (
    .clk(clk), .rst(rst), .rx_data(rx_data_b), .rx_valid(rx_valid_b),
    .tx_data(tx_data_b), .tx_valid(tx_valid_b), .addr_err(addr_err_b)
  );

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One command, returns at the falling edge right after the accepting edge
  task automatic send(input bit sel, input logic [1:0] c, input logic [7:0] p);
    @(negedge clk);
    if (sel) begin rx_data_b = {c, p}; rx_valid_b = 1'b1; end
    else     begin rx_data_a = {c, p}; rx_valid_a = 1'b1; end
    @(negedge clk);
    rx_valid_a = 1'b0;
    rx_valid_b = 1'b0;
  endtask

  // Read command compared against the scoreboard head
  task automatic read_chk(input bit sel, input string tag);
    logic [7:0] e;
    send(sel, 2'b11, 8'h00);
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 16'd0, 16'd1);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_data"}, sel ? 16'(tx_data_b) : 16'(tx_data_a), 16'(e));
      chk({tag, "_valid"}, sel ? 16'(tx_valid_b) : 16'(tx_valid_a), 16'd1);
    end
  endtask

  initial begin
    // Reset with the clock stopped
    #7 rst = 1'b1;
    #1;
    chk("rst_tx_valid", 16'(tx_valid_a), 16'd0);
    chk("rst_tx_data", 16'(tx_data_a), 16'd0);
    chk("rst_addr_err", 16'(addr_err_a), 16'd0);
    chk("rst128_tx_valid", 16'(tx_valid_b), 16'd0);
    clk_en = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Basic write / read
    send(0, 2'b00, 8'h12);
    chk("basic_addr_err", 16'(addr_err_a), 16'd0);
    send(0, 2'b01, 8'hA5);
    send(0, 2'b10, 8'h12);
    exp_q.push_back(8'hA5);
    read_chk(0, "basic_rd");

    // Non-read command clears tx_valid, tx_data holds
    send(0, 2'b00, 8'h00);
    chk("clr_tx_valid", 16'(tx_valid_a), 16'd0);
    chk("clr_tx_hold", 16'(tx_data_a), 16'h00A5);

    // Auto-increment wrap at the top address
    send(0, 2'b00, 8'hFF);
    send(0, 2'b01, 8'h11);
    send(0, 2'b01, 8'h22);
    send(0, 2'b10, 8'hFF);
    exp_q.push_back(8'h11);
    read_chk(0, "wrap_rd0");
    exp_q.push_back(8'h22);
    read_chk(0, "wrap_rd1");

    // Level hold: 20 cycles of rx_valid high writes once
    send(0, 2'b00, 8'h40);
    send(0, 2'b01, 8'h00);
    send(0, 2'b01, 8'h00);
    send(0, 2'b01, 8'h77);
    send(0, 2'b00, 8'h40);
    @(negedge clk);
    rx_data_a = {2'b01, 8'h55};
    rx_valid_a = 1'b1;
    repeat (20) @(negedge clk);
    rx_valid_a = 1'b0;
    send(0, 2'b01, 8'h66);
    send(0, 2'b10, 8'h40);
    exp_q.push_back(8'h55);
    read_chk(0, "hold_rd40");
    exp_q.push_back(8'h66);
    read_chk(0, "hold_rd41");
    exp_q.push_back(8'h77);
    read_chk(0, "hold_rd42");

    // Reset on the edge of a write, rx_valid still high afterwards
    send(0, 2'b00, 8'h01);
    send(0, 2'b01, 8'h33);
    send(0, 2'b00, 8'h50);
    send(0, 2'b01, 8'h99);
    send(0, 2'b00, 8'h50);
    @(negedge clk);
    rx_data_a = {2'b01, 8'hAB};
    rx_valid_a = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_tx_valid", 16'(tx_valid_a), 16'd0);
    rst = 1'b0;
    @(negedge clk);
    rx_valid_a = 1'b0;
    send(0, 2'b10, 8'h50);
    exp_q.push_back(8'h99);
    read_chk(0, "rstmid_rd50");
    send(0, 2'b10, 8'h00);
    exp_q.push_back(8'hAB);
    read_chk(0, "rstmid_rd00");
    exp_q.push_back(8'h33);
    read_chk(0, "rstmid_rd01");

    // Out-of-range addresses on the 128-deep instance
    send(1, 2'b00, 8'h10);
    send(1, 2'b01, 8'h5A);
    send(1, 2'b00, 8'h80);
    chk("oor_wr_err_hi", 16'(addr_err_b), 16'd1);
    @(negedge clk);
    chk("oor_wr_err_lo", 16'(addr_err_b), 16'd0);
    send(1, 2'b01, 8'h6B);
    chk("oor_data_err", 16'(addr_err_b), 16'd0);
    send(1, 2'b10, 8'h11);
    send(1, 2'b10, 8'h90);
    chk("oor_rd_err_hi", 16'(addr_err_b), 16'd1);
    @(negedge clk);
    chk("oor_rd_err_lo", 16'(addr_err_b), 16'd0);
    exp_q.push_back(8'h6B);
    read_chk(1, "oor_rd11");
    send(1, 2'b10, 8'h10);
    exp_q.push_back(8'h5A);
    read_chk(1, "oor_rd10");

    // Highest legal address is accepted
    send(1, 2'b00, 8'h7F);
    chk("edge_7f_err", 16'(addr_err_b), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
